// File: rtl/squareroot_mahsqr_k12.sv
// squareroot_mahsqr_k12: 2-stage pipelined approximate 16-bit sqrt via leading-one normalisation and a chord fit
module squareroot_mahsqr_k12 #(
    parameter int K = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] R,
    output logic        out_valid,
    output logic [7:0]  final_op
);
    localparam logic [K+1:0] A_EVEN = (K+2)'(1 << K);
    localparam logic [K+1:0] A_ODD  = (K+2)'(5793);
    localparam logic [K-1:0] B_EVEN = K'(1697);
    localparam logic [K-1:0] B_ODD  = K'(2399);
    logic [3:0]     p;
    logic [15:0]    frac;
    logic [K-1:0]   f_k_d;
    logic           v1;
    logic [2:0]     e;
    logic           odd;
    logic [K-1:0]   f_k;
    logic           zero;
    logic [2*K-1:0] prod;
    logic [K+1:0]   y;
    logic [K+8:0]   scaled;
    logic [8:0]     r;
    logic [7:0]     res;
    always_comb begin
        p = '0;
        for (int i = 1; i < 16; i++)
            if (R[i]) p = i[3:0];
    end
    // shifting past the leading one leaves the fraction left-aligned at bit 15
    assign frac  = R << (5'd16 - {1'b0, p});
    assign f_k_d = K'(frac >> (16 - K));
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            e    <= '0;
            odd  <= 1'b0;
            f_k  <= '0;
            zero <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                e    <= p[3:1];
                odd  <= p[0];
                f_k  <= f_k_d;
                zero <= (R == 16'd0);
            end
        end
    end
    assign prod   = (2*K)'(f_k) * (2*K)'(odd ? B_ODD : B_EVEN);
    assign y      = (odd ? A_ODD : A_EVEN) + (K+2)'(prod >> K);
    assign scaled = ((K+9)'(y) << e) + (K+9)'(1 << (K-1));
    assign r      = 9'(scaled >> K);
    assign res    = zero ? 8'd0 : (r[8] ? 8'hFF : r[7:0]);
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            final_op  <= '0;
        end else begin
            out_valid <= v1;
            if (v1) final_op <= res;
        end
    end
endmodule

// File: tb/tb_squareroot_mahsqr_k12.sv
// tb_squareroot_mahsqr_k12: table vectors, directed corner sequences, random traffic and a full sweep against a reference model
module tb_squareroot_mahsqr_k12;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] R = '0;
    logic        out_valid;
    logic [7:0]  final_op;
    int checks = 0;
    int errors = 0;

    squareroot_mahsqr_k12 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .R(R),
        .out_valid(out_valid), .final_op(final_op)
    );

    always #5 clk = ~clk;

    function automatic int ref_sqrt(input int r);
        int p, e, fk, y, res;
        if (r == 0) return 0;
        p = 0;
        while ((2 << p) <= r) p++;
        e  = p / 2;
        fk = ((r - (1 << p)) << (15 - p)) / 8;
        y  = (p % 2 == 0) ? 4096 + (1697 * fk) / 4096 : 5793 + (2399 * fk) / 4096;
        res = ((y << e) + 2048) / 4096;
        return (res > 255) ? 255 : res;
    endfunction

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // cycle-level expectation: an accepted sample appears two edges later
    logic m_ov = 1'b0, p_iv = 1'b0;
    int   m_op = 0, m_r = 0, p_r = 0;
    bit   mon_en = 1'b0, sweep = 1'b0, have_prev = 1'b0;
    int   prev_op = 0;
    real  s_r, d_r;

    always @(posedge clk) begin
        m_ov <= !rst && p_iv;
        if (rst) m_op <= 0;
        else if (p_iv) begin
            m_op <= ref_sqrt(p_r);
            m_r  <= p_r;
        end
        p_iv <= in_valid && !rst;
        p_r  <= int'(R);
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon out_valid", int'(out_valid), int'(m_ov));
            chk("mon final_op", int'(final_op), m_op);
            if (sweep && out_valid) begin
                if (have_prev) chk($sformatf("monotonic R=%0d", m_r), int'(final_op >= prev_op), 1);
                s_r = $sqrt(real'(m_r));
                d_r = real'(final_op) - $floor(s_r + 0.5);
                if (d_r < 0.0) d_r = -d_r;
                chk($sformatf("error bound R=%0d", m_r), int'(d_r <= 1.0 + 0.015 * s_r), 1);
                prev_op   = int'(final_op);
                have_prev = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] r;
        int          exp;
    } vec_t;
    vec_t vecs[11];

    initial begin
        vecs[0]  = '{16'd12, 3};
        vecs[1]  = '{16'd10, 3};
        vecs[2]  = '{16'd15, 4};
        vecs[3]  = '{16'd3, 2};
        vecs[4]  = '{16'd9, 3};
        vecs[5]  = '{16'd0, 0};
        vecs[6]  = '{16'd1, 1};
        vecs[7]  = '{16'd256, 16};
        vecs[8]  = '{16'hE600, 241};
        vecs[9]  = '{16'hFFFF, 255};
        vecs[10] = '{16'hE002, 237};

        rst = 1'b1; in_valid = 1'b1; R = 16'd100;
        step();
        mon_en = 1'b1;
        chk("reset out_valid c1", int'(out_valid), 0);
        chk("reset final_op c1", int'(final_op), 0);
        step();
        chk("reset out_valid c2", int'(out_valid), 0);
        chk("reset final_op c2", int'(final_op), 0);
        rst = 1'b0;
        step();
        chk("post-release out_valid", int'(out_valid), 0);
        chk("post-release final_op", int'(final_op), 0);
        in_valid = 1'b0;
        step();
        chk("first out_valid", int'(out_valid), 1);
        chk("first final_op R=100", int'(final_op), 10);
        step();
        chk("idle out_valid", int'(out_valid), 0);
        chk("idle hold final_op", int'(final_op), 10);

        for (int i = 0; i <= 11; i++) begin
            if (i < 11) begin
                in_valid = 1'b1;
                R = vecs[i].r;
            end else in_valid = 1'b0;
            step();
            if (i > 0) begin
                chk("vec out_valid", int'(out_valid), 1);
                chk($sformatf("vec R=%0d", vecs[i-1].r), int'(final_op), vecs[i-1].exp);
            end
        end
        step();
        chk("vec drain out_valid", int'(out_valid), 0);
        chk("vec drain hold", int'(final_op), 237);

        for (int i = 0; i < 12; i++) begin
            in_valid = (i % 2 == 0);
            R = 16'($urandom);
            step();
        end
        in_valid = 1'b0;
        step(); step();

        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            R = 16'($urandom);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        step();
        chk("mid reset out_valid", int'(out_valid), 0);
        chk("mid reset final_op", int'(final_op), 0);
        step();
        chk("mid reset flushed", int'(out_valid), 0);

        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            R = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0;
        step(); step(); step();

        sweep = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            R = 16'(i);
            step();
        end
        in_valid = 1'b0;
        step(); step(); step();
        sweep = 1'b0;
        chk("sweep last output", prev_op, 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
